// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;
    localparam int unsigned AW_DEFAULT       = 10;
    localparam int unsigned DW_DEFAULT       = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE      = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    function automatic logic is_halt_op(input logic [3:0] opcode);
        return opcode == HALT_OPCODE;
    endfunction
endpackage

// File: rtl/sum16bit.sv
// Plain 16-bit modulo adder, used as the fetch PC incrementer.
module sum16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, one-entry skid for decode
// back-pressure, redirect squashing and a shared program-loader write port.
//
//   state    | meaning
//   ST_IDLE  | fetch disabled, in-flight read may still drain
//   ST_FETCH | issuing one read per cycle while allowed
//   ST_HALT  | halt opcode reached; waits for redirect with en
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned AW       = AW_DEFAULT,
    parameter int unsigned DW       = DW_DEFAULT,
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [15:0]   redirect_pc_i,
    input  logic          ld_req_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_data_i,
    output logic          ld_gnt_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [DW-1:0] isr_o,
    output logic          isr_valid_o,
    output logic [15:0]   pc_o,
    output logic          halted_o
);
    fetch_state_e  state_q, state_d;
    logic [15:0]   pc_q, pc_d, pc_inc;
    logic [DW-1:0] isr_q, isr_d;
    logic          isr_valid_q, isr_valid_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          skid_vld_q, skid_vld_d;
    logic          inflight_q, inflight_d;

    logic          load_isr;
    logic [DW-1:0] load_word;
    logic          halt_load;
    logic          issue;

    sum16bit u_pc_inc (
        .a_i   (pc_q),
        .b_i   (16'h0001),
        .sum_o (pc_inc)
    );

    // A word reaches isr from the skid first, otherwise straight from memory.
    always_comb begin
        load_word = skid_vld_q ? skid_q : mem_rdata_i;
        load_isr  = !redirect_i && !stall_i && (skid_vld_q || inflight_q);
        halt_load = load_isr && (state_q == ST_FETCH) && is_halt_op(load_word[DW-1 -: 4]);
        // No read is issued alongside a halt word, so nothing trails it into HALT.
        issue     = (state_q == ST_FETCH) && en_i && !stall_i && !ld_req_i
                    && !redirect_i && !skid_vld_q && !halt_load;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        isr_d       = isr_q;
        isr_valid_d = isr_valid_q;
        skid_d      = skid_q;
        skid_vld_d  = skid_vld_q;
        inflight_d  = issue;

        if (redirect_i) begin
            pc_d        = redirect_pc_i;
            isr_valid_d = 1'b0;
            skid_vld_d  = 1'b0;
        end else begin
            if (issue) begin
                pc_d = pc_inc;
            end
            if (!stall_i) begin
                isr_valid_d = load_isr;
                skid_vld_d  = 1'b0;
                if (load_isr) begin
                    isr_d = load_word;
                end
            end else if (inflight_q) begin
                skid_d     = mem_rdata_i;
                skid_vld_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE:  if (en_i) state_d = ST_FETCH;
            ST_FETCH: begin
                if (halt_load)  state_d = ST_HALT;
                else if (!en_i) state_d = ST_IDLE;
            end
            ST_HALT:  if (redirect_i && en_i) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            isr_q       <= '0;
            isr_valid_q <= 1'b0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            isr_q       <= isr_d;
            isr_valid_q <= isr_valid_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            inflight_q  <= inflight_d;
        end
    end

    // The loader owns the memory port whenever it asks; writes are blocked in reset.
    assign ld_gnt_o    = ld_req_i && rst_n_i;
    assign mem_we_o    = ld_gnt_o;
    assign mem_addr_o  = ld_req_i ? ld_addr_i : pc_q[AW-1:0];
    assign mem_wdata_o = mem_we_o ? ld_data_i : '0;

    assign isr_o       = isr_q;
    assign isr_valid_o = isr_valid_q;
    assign pc_o        = pc_q;
    assign halted_o    = (state_q == ST_HALT);
endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised and directed bench for fetch_ctrl against a queue-based fetch model.
module tb_fetch_ctrl;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          en_i, stall_i, redirect_i, ld_req_i;
    logic [15:0]   redirect_pc_i;
    logic [AW-1:0] ld_addr_i;
    logic [DW-1:0] ld_data_i;
    logic          ld_gnt_o, mem_we_o, isr_valid_o, halted_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, isr_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [15:0]   pc_o;

    fetch_ctrl #(.AW(AW), .DW(DW), .RESET_PC(16'h0000)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
        .ld_gnt_o(ld_gnt_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .isr_o(isr_o), .isr_valid_o(isr_valid_o), .pc_o(pc_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    logic [DW-1:0] mem [1024];
    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= mem[mem_addr_o];
    end

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] seen[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words fetched but not yet handed to decode, stamped with issue cycle.
    typedef struct { logic [DW-1:0] w; int stamp; } ent_t;
    ent_t          q[$];
    logic [DW-1:0] m_mem [1024];
    logic [15:0]   m_pc;
    logic [DW-1:0] m_isr;
    logic          m_valid;
    int            m_mode;
    int            cyc;

    initial begin
        bit stepped, skid_full, halt_now, issue, loaded_halt;
        ent_t e;
        cyc = 0;
        stepped = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                q.delete();
                m_pc = 16'h0000; m_isr = '0; m_valid = 0; m_mode = MODE_IDLE;
                stepped = 0;
            end else begin
                skid_full = (q.size() > 0) && (q[0].stamp != cyc - 1);
                halt_now  = (q.size() > 0) && !stall_i && (m_mode == MODE_RUN)
                            && (q[0].w[15:12] == 4'hF);
                issue = (m_mode == MODE_RUN) && en_i && !stall_i && !ld_req_i
                        && !redirect_i && !skid_full && !halt_now;
                chk("ld_gnt", ld_gnt_o, ld_req_i);
                chk("mem_we", mem_we_o, ld_req_i);
                chk("mem_wdata", mem_wdata_o, ld_req_i ? ld_data_i : 16'h0000);
                if (ld_req_i)   chk("mem_addr_ld", mem_addr_o, ld_addr_i);
                else if (issue) chk("mem_addr_fetch", mem_addr_o, m_pc[AW-1:0]);

                if (redirect_i) begin
                    q.delete();
                    m_valid = 0;
                    m_pc = redirect_pc_i;
                    if (en_i) m_mode = MODE_RUN;
                    else if (m_mode == MODE_RUN) m_mode = MODE_IDLE;
                end else begin
                    loaded_halt = 0;
                    if (!stall_i) begin
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            m_isr = e.w;
                            m_valid = 1;
                            loaded_halt = (m_mode == MODE_RUN) && (e.w[15:12] == 4'hF);
                        end else begin
                            m_valid = 0;
                        end
                    end
                    if (loaded_halt) m_mode = MODE_HALT;
                    else if (m_mode == MODE_RUN && !en_i) m_mode = MODE_IDLE;
                    else if (m_mode == MODE_IDLE && en_i) m_mode = MODE_RUN;
                    if (issue) begin
                        e.w = m_mem[m_pc[AW-1:0]];
                        e.stamp = cyc;
                        q.push_back(e);
                        m_pc = m_pc + 16'd1;
                    end
                end
                if (ld_req_i) m_mem[ld_addr_i] = ld_data_i;
                stepped = 1;
            end
            @(posedge clk_i);
            cyc++;
            #1;
            if (stepped && rst_n_i) begin
                chk("pc", pc_o, m_pc);
                chk("isr_valid", isr_valid_o, m_valid);
                chk("isr", isr_o, m_isr);
                chk("halted", halted_o, m_mode == MODE_HALT);
                if (isr_valid_o) seen.push_back(isr_o);
            end
        end
    end

    task automatic setin(input bit en, input bit st, input bit rd, input logic [15:0] rpc,
                         input bit ld, input logic [AW-1:0] la, input logic [DW-1:0] ldd);
        en_i = en; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
        ld_req_i = ld; ld_addr_i = la; ld_data_i = ldd;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic step(input bit en, input bit st, input bit rd, input logic [15:0] rpc);
        setin(en, st, rd, rpc, 0, '0, '0);
        tick();
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        setin(0, 0, 0, 16'h0, 1, a, d);
        tick();
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0);
    endtask

    initial begin
        logic [15:0] pc_before;
        logic [15:0] rpc;
        rst_n_i = 0;
        setin(0, 0, 0, 16'h0, 0, '0, '0);
        tick(); tick(); tick();
        chk("rst_pc", pc_o, 16'h0000);
        chk("rst_isr", isr_o, 16'h0000);
        chk("rst_isr_valid", isr_valid_o, 1'b0);
        chk("rst_halted", halted_o, 1'b0);
        setin(0, 0, 0, 16'h0, 1, 10'h001, 16'h1234);
        #1;
        chk("rst_mem_we", mem_we_o, 1'b0);
        setin(0, 0, 0, 16'h0, 0, '0, '0);
        tick();
        rst_n_i = 1;

        for (int a = 0; a < 1024; a++)
            load(a[AW-1:0], (a < 4) ? 16'h1001 + 16'(a) : 16'($urandom) & 16'h7FFF);

        // Four sequential fetches from reset PC.
        seen.delete();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0);
        quiet(4);
        chk("seq_count", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("seq_word", seen[i], 16'h1001 + 16'(i));
        chk("seq_pc", pc_o, 16'h0004);

        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) begin
                step(1, 0, 1, 16'h0040);
                step(1, 0, 0, 16'h0);
                rst_n_i = 0;
                setin(0, 0, 0, 16'h0, 0, '0, '0);
                tick(); tick();
                rst_n_i = 1;
                step(1, 0, 0, 16'h0);
                setin(1, 0, 0, 16'h0, 0, '0, '0);
                #1;
                chk("post_reset_addr", mem_addr_o, 10'h000);
                tick();
            end
            case ($urandom_range(0, 3))
                0:       rpc = 16'h03FD + 16'($urandom_range(0, 3));
                1:       rpc = 16'hFFFD + 16'($urandom_range(0, 2));
                default: rpc = 16'($urandom);
            endcase
            setin($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) == 0,
                  AW'($urandom), DW'($urandom));
            tick();
        end
        quiet(3);

        // Stall over a returning read.
        load(10'h010, 16'h2010); load(10'h011, 16'h2011); load(10'h012, 16'h2012);
        step(1, 0, 1, 16'h0010);
        seen.delete();
        step(1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 16'h0);
        chk("stall_no_output", seen.size(), 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0);
        quiet(3);
        chk("stall_count", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            chk("stall_word", seen[i], 16'h2010 + 16'(i));

        // Redirect squashes an in-flight read.
        load(10'h005, 16'h5555); load(10'h200, 16'h2200);
        step(1, 0, 1, 16'h0005);
        seen.delete();
        step(1, 0, 0, 16'h0);
        step(1, 0, 1, 16'h0200);
        step(1, 0, 0, 16'h0);
        quiet(3);
        chk("squash_count", seen.size(), 1);
        if (seen.size() > 0) chk("squash_target", seen[0], 16'h2200);

        // Loader write during FETCH holds the PC.
        step(1, 0, 1, 16'h0030);
        setin(1, 0, 0, 16'h0, 1, 10'h005, 16'hABCD);
        #1;
        chk("ld_fetch_we", mem_we_o, 1'b1);
        chk("ld_fetch_addr", mem_addr_o, 10'h005);
        chk("ld_fetch_wdata", mem_wdata_o, 16'hABCD);
        pc_before = pc_o;
        tick();
        chk("ld_fetch_pc_hold", pc_o, pc_before);
        quiet(2);
        step(1, 0, 1, 16'h0005);
        seen.delete();
        step(1, 0, 0, 16'h0);
        quiet(3);
        chk("ld_readback_count", seen.size(), 1);
        if (seen.size() > 0) chk("ld_readback", seen[0], 16'hABCD);

        // Halt opcode and resume by redirect.
        load(10'h000, 16'h1001); load(10'h001, 16'h1002);
        load(10'h002, 16'hF000); load(10'h003, 16'h1004);
        step(1, 0, 1, 16'h0000);
        seen.delete();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 16'h0);
        chk("halt_flag", halted_o, 1'b1);
        chk("halt_pc", pc_o, 16'h0003);
        chk("halt_isr", isr_o, 16'hF000);
        chk("halt_count", seen.size(), 3);
        if (seen.size() == 3) chk("halt_last", seen[2], 16'hF000);
        load(10'h002, 16'h3333);
        step(1, 0, 1, 16'h0000);
        seen.delete();
        step(1, 0, 0, 16'h0); step(1, 0, 0, 16'h0);
        quiet(3);
        chk("resume_halted", halted_o, 1'b0);
        chk("resume_count", seen.size(), 2);
        if (seen.size() > 0) chk("resume_first", seen[0], 16'h1001);

        // Memory index wraps at the address width, PC does not.
        step(1, 0, 1, 16'h03FF);
        setin(1, 0, 0, 16'h0, 0, '0, '0);
        #1;
        chk("wrap_addr0", mem_addr_o, 10'h3FF);
        tick();
        setin(1, 0, 0, 16'h0, 0, '0, '0);
        #1;
        chk("wrap_addr1", mem_addr_o, 10'h000);
        tick();
        quiet(3);
        chk("wrap_pc", pc_o, 16'h0401);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
